// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, bit-timing helpers and the
// width of the dropped-byte counter.
package uart_pkg;

  localparam int DROP_COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Clocks per serial bit.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clocks from the start-bit edge to the middle of the start bit.
  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input. Resets to 1 so an
// idle-high line is not seen as a falling edge on reset release.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  // Two-stage metastability filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// UART receiver feeding the rx_fifo write port. Bytes that arrive while the
// FIFO is full, or with a bad stop bit, are dropped and counted; the serial
// line cannot be paused so there is no stall path.
// Optional even-parity bit and parity_err output: define UART_RX_PARITY_EN.
module uart_rx_fifo_writer
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    serial_in,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_din,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                    parity_err,
`endif
  output logic [DROP_COUNT_W-1:0] drop_count
);

  localparam int SET = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SMP = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(SET) + 1;
  localparam int BW  = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] SET_M1 = CW'(SET - 1);
  localparam logic [CW-1:0] SMP_M1 = CW'(SMP - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [DROP_COUNT_W-1:0] DROP_MAX = '1;

  logic rx_s;
  logic rx_prev_q;
  logic fall;

  uart_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic                   wr_q, wr_d;
  logic [WIDTH-1:0]       dout_q, dout_d;
  logic                   fe_q, fe_d;
  logic                   ov_q, ov_d;
  logic [DROP_COUNT_W-1:0] drop_q, drop_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   pe_q, pe_d;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (serial_in),
    .q_o   (rx_s)
  );

  // Edge detect needs the line to be seen high first, so a line stuck low
  // after a frame error never retriggers.
  assign fall = rx_prev_q & ~rx_s;

  // Next-state / datapath for the receive FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    wr_d    = 1'b0;
    dout_d  = dout_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    drop_d  = drop_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (cnt_q == SMP_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;              // glitch shorter than half a bit
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_q == SET_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[WIDTH-1:1]};   // LSB arrives first
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == SET_M1) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q);  // even parity over data bits
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving mid-stop-bit leaves half a bit of margin to catch the
        // next start edge in back-to-back traffic.
        if (cnt_q == SET_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            fe_d   = 1'b1;
            drop_d = (drop_q == DROP_MAX) ? drop_q : drop_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            pe_d   = 1'b1;
            drop_d = (drop_q == DROP_MAX) ? drop_q : drop_q + 1'b1;
`endif
          end else if (fifo_full) begin
            ov_d   = 1'b1;
            drop_d = (drop_q == DROP_MAX) ? drop_q : drop_q + 1'b1;
          end else begin
            wr_d   = 1'b1;
            dout_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_q      <= 1'b0;
      dout_q    <= '0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      drop_q    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_q      <= wr_d;
      dout_q    <= dout_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      drop_q    <= drop_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign fifo_wr_en  = wr_q;
  assign fifo_din    = dout_q;
  assign busy        = (state_q != IDLE);
  assign frame_err   = fe_q;
  assign overrun_err = ov_q;
  assign drop_count  = drop_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = pe_q;
`endif

endmodule
